// File: rtl/enemy_column_ctrl.sv
// ---------------------------------------------------------------------------
// enemy_column_ctrl
//
// Controller for one column of ROWS stacked enemies. It keeps an alive mask
// instead of per-sprite hit/death state, runs the column's march state
// machine, checks the player bullet against every row each cycle, adds up
// score, and shortens the step delay as enemies die.
//
// The formation top level ORs the left/right flags of all columns and feeds
// them back as left_in/right_in. The sprite renderer consumes x, y, alive and
// frame.
//
// Ports:
//   clk       clock
//   reset     synchronous, active-high reset
//   tick      one-cycle strobe, once per frame after drawing
//   left_in   some column of the formation is at the left edge
//   right_in  some column of the formation is at the right edge
//   b_valid   player bullet active this cycle
//   bx, by    bullet position
//   x         column x
//   y         y of row 0 (top row)
//   alive     per-row alive mask, bit 0 = top row
//   left      this column is at or past X_MIN and has an enemy alive
//   right     this column is at or past X_MAX and has an enemy alive
//   b_hit     one-cycle pulse when a kill occurs
//   move      high for one tick period after a step or drop
//   frame     animation frame bit, toggles on each step or drop
//   all_dead  no enemy left in this column
//   gg        an alive enemy has reached GG_Y (sticky until reset)
//   score     sum of points for dead rows
// ---------------------------------------------------------------------------
module enemy_column_ctrl #(
    parameter int ROWS         = 5,
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter int CELL_W       = 12,
    parameter int CELL_H       = 8,
    parameter int ROW_PITCH    = 13,
    parameter int STEP_X       = 2,
    parameter int STEP_Y       = 8,
    parameter int X_MIN        = 4,
    parameter int X_MAX        = 228,
    parameter int START_X      = 2,
    parameter int START_Y      = 0,
    parameter int GG_Y         = 200,
    parameter int DELAY_INIT   = 63,
    parameter int DELAY_MIN    = 2,
    parameter int KILL_SPEEDUP = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            left_in,
    input  logic            right_in,
    input  logic            b_valid,
    input  logic [X_W-1:0]  bx,
    input  logic [Y_W-1:0]  by,
    output logic [X_W-1:0]  x,
    output logic [Y_W-1:0]  y,
    output logic [ROWS-1:0] alive,
    output logic            left,
    output logic            right,
    output logic            b_hit,
    output logic            move,
    output logic            frame,
    output logic            all_dead,
    output logic            gg,
    output logic [10:0]     score
);

    localparam int DLY_W = (DELAY_INIT < 2) ? 1 : $clog2(DELAY_INIT + 1);
    localparam int CNT_W = (ROWS < 2) ? 1 : $clog2(ROWS + 1);

    // March direction is encoded in the state: *_R marches right, *_L left.
    typedef enum logic [2:0] {
        IDLE_R,
        STEP_R,
        DOWN_R,
        IDLE_L,
        STEP_L,
        DOWN_L
    } state_t;

    state_t ps, ns;

    logic [DLY_W-1:0] delay;
    logic [DLY_W-1:0] delay_set;
    int               delay_calc;
    logic [CNT_W-1:0] dead_count;

    // Box bounds are one bit wider than the coordinates so x+CELL_W and
    // y+r*ROW_PITCH+CELL_H never wrap back into the playfield.
    logic [X_W:0]     bx_ext;
    logic [X_W:0]     x_lo;
    logic [X_W:0]     x_hi;
    logic [Y_W:0]     by_ext;
    logic [Y_W:0]     row_top [ROWS];
    logic [Y_W:0]     row_bot [ROWS];

    logic [ROWS-1:0]  row_hit;
    logic [ROWS-1:0]  kill_mask;
    logic             hit_any;
    logic [10:0]      hit_pts;
    logic             gg_reach;
    logic             stepping;

    // Top row is worth the most, upper half of the rest medium, bottom least.
    function automatic logic [10:0] row_points(input int r);
        if (r == 0)
            return 11'd40;
        else if (r <= ROWS / 2)
            return 11'd20;
        else
            return 11'd10;
    endfunction

    // -----------------------------------------------------------------------
    // Status flags
    // -----------------------------------------------------------------------
    assign all_dead = ~|alive;
    assign left     = (x <= X_W'(X_MIN)) & ~all_dead;
    assign right    = (x >= X_W'(X_MAX)) & ~all_dead;

    assign stepping = (ps == STEP_R) || (ps == STEP_L) ||
                      (ps == DOWN_R) || (ps == DOWN_L);

    // -----------------------------------------------------------------------
    // Row boxes, bullet test and invasion test
    // -----------------------------------------------------------------------
    assign bx_ext = {1'b0, bx};
    assign by_ext = {1'b0, by};
    assign x_lo   = {1'b0, x};
    assign x_hi   = x_lo + (X_W+1)'(CELL_W);

    always_comb begin
        // NOTE: every variable written here gets a default before any
        // conditional logic, so no path leaves one unassigned (no latch).
        row_hit  = '0;
        gg_reach = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            row_top[r] = {1'b0, y} + (Y_W+1)'(r * ROW_PITCH);
            row_bot[r] = row_top[r] + (Y_W+1)'(CELL_H);
            row_hit[r] = b_valid & alive[r] &
                         (bx_ext >= x_lo) & (bx_ext < x_hi) &
                         (by_ext >= row_top[r]) & (by_ext < row_bot[r]);
            if (alive[r] && (row_bot[r] > (Y_W+1)'(GG_Y)))
                gg_reach = 1'b1;
        end
    end

    // Later (lower) rows overwrite earlier ones, so the bottom-most matching
    // row is the one killed.
    always_comb begin
        hit_any   = 1'b0;
        kill_mask = '0;
        hit_pts   = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_hit[r]) begin
                hit_any      = 1'b1;
                kill_mask    = '0;
                kill_mask[r] = 1'b1;
                hit_pts      = row_points(r);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Step delay: shrinks with each dead enemy, floored at DELAY_MIN.
    // Uses the registered alive mask, so a kill landing on a tick does not
    // affect that tick's reload.
    // -----------------------------------------------------------------------
    always_comb begin
        dead_count = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!alive[r])
                dead_count = dead_count + CNT_W'(1);
        end
    end

    always_comb begin
        delay_calc = DELAY_INIT - KILL_SPEEDUP * int'(dead_count);
        if (delay_calc < DELAY_MIN)
            delay_calc = DELAY_MIN;
        delay_set = DLY_W'(delay_calc);
    end

    // -----------------------------------------------------------------------
    // March state machine
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of evaluation order.
        if (reset)
            ps <= IDLE_R;
        else
            ps <= ns;
    end

    // Only ticks advance the machine; an empty column freezes it.
    always_comb begin
        ns = ps;
        if (tick && !all_dead) begin
            case (ps)
                IDLE_R: if (delay == '0) ns = right_in ? DOWN_R : STEP_R;
                STEP_R: ns = IDLE_R;
                DOWN_R: ns = IDLE_L;
                IDLE_L: if (delay == '0) ns = left_in ? DOWN_L : STEP_L;
                STEP_L: ns = IDLE_L;
                DOWN_L: ns = IDLE_R;
                default: ns = IDLE_R;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Position, animation, kills, score and invasion flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            x     <= X_W'(START_X);
            y     <= Y_W'(START_Y);
            alive <= '1;
            score <= '0;
            b_hit <= 1'b0;
            move  <= 1'b0;
            frame <= 1'b0;
            gg    <= 1'b0;
            delay <= DLY_W'(DELAY_INIT);
        end else begin
            // Hits are independent of tick; the kill clears the alive bit,
            // so a bullet held on the same row cannot score twice.
            b_hit <= hit_any;
            if (hit_any) begin
                alive <= alive & ~kill_mask;
                score <= score + hit_pts;
            end

            if (gg_reach)
                gg <= 1'b1;

            if (tick) begin
                delay <= (delay == '0) ? delay_set : delay - DLY_W'(1);
                move  <= stepping & ~all_dead;
                if (!all_dead) begin
                    case (ps)
                        STEP_R:         x <= x + X_W'(STEP_X);
                        STEP_L:         x <= x - X_W'(STEP_X);
                        DOWN_R, DOWN_L: y <= y + Y_W'(STEP_Y);
                        default: ;
                    endcase
                    if (stepping)
                        frame <= ~frame;
                end
            end
        end
    end

endmodule

// File: tb/tb_enemy_column_ctrl.sv
// ---------------------------------------------------------------------------
// tb_enemy_column_ctrl
//
// Self-checking bench for enemy_column_ctrl. Two instances share clock,
// reset, tick and the edge inputs: dut uses default parameters, dut_f uses
// KILL_SPEEDUP=20 to reach the delay floor. Bullet vectors come from a table
// of {offsets, expected outputs}; each vector pushes its expectation into a
// queue tagged with the cycle it is due, and a monitor pops and compares it
// when the DUT registers the result. March timing is checked by counting
// ticks between move pulses against the bench's own position model.
// ---------------------------------------------------------------------------
module tb_enemy_column_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic        left_in;
    logic        right_in;

    logic        b_valid;
    logic [9:0]  bx;
    logic [8:0]  by;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [4:0]  alive;
    logic        left, right, b_hit, move, frame, all_dead, gg;
    logic [10:0] score;

    logic        b_valid_f;
    logic [9:0]  bx_f;
    logic [8:0]  by_f;
    logic [9:0]  x_f;
    logic [8:0]  y_f;
    logic [4:0]  alive_f;
    logic        left_f, right_f, b_hit_f, move_f, frame_f, all_dead_f, gg_f;
    logic [10:0] score_f;

    always #5 clk = ~clk;

    enemy_column_ctrl dut (
        .clk(clk), .reset(reset), .tick(tick),
        .left_in(left_in), .right_in(right_in),
        .b_valid(b_valid), .bx(bx), .by(by),
        .x(x), .y(y), .alive(alive), .left(left), .right(right),
        .b_hit(b_hit), .move(move), .frame(frame),
        .all_dead(all_dead), .gg(gg), .score(score)
    );

    enemy_column_ctrl #(.KILL_SPEEDUP(20)) dut_f (
        .clk(clk), .reset(reset), .tick(tick),
        .left_in(left_in), .right_in(right_in),
        .b_valid(b_valid_f), .bx(bx_f), .by(by_f),
        .x(x_f), .y(y_f), .alive(alive_f), .left(left_f), .right(right_f),
        .b_hit(b_hit_f), .move(move_f), .frame(frame_f),
        .all_dead(all_dead_f), .gg(gg_f), .score(score_f)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic bound_expired(input string name);
        total++;
        bad++;
        $display("FAIL %s: no move pulse within the tick budget", name);
    endtask

    // -----------------------------------------------------------------------
    // Scoreboard
    // -----------------------------------------------------------------------
    typedef struct {
        int          due;
        bit          fast;
        logic        eh;
        logic [4:0]  ea;
        logic [10:0] es;
        int          tag;
    } sb_t;

    sb_t exp_q[$];
    sb_t mon_e;

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            mon_e = exp_q.pop_front();
            if (mon_e.fast) begin
                check($sformatf("f_hit%0d_b_hit", mon_e.tag), b_hit_f, mon_e.eh);
                check($sformatf("f_hit%0d_alive", mon_e.tag), alive_f, mon_e.ea);
                check($sformatf("f_hit%0d_score", mon_e.tag), score_f, mon_e.es);
            end else begin
                check($sformatf("hit%0d_b_hit", mon_e.tag), b_hit, mon_e.eh);
                check($sformatf("hit%0d_alive", mon_e.tag), alive, mon_e.ea);
                check($sformatf("hit%0d_score", mon_e.tag), score, mon_e.es);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    typedef struct {
        logic        bv;
        int          dx;
        int          dy;
        logic        eh;
        logic [4:0]  ea;
        logic [10:0] es;
    } hit_vec_t;

    hit_vec_t hit_tab [18];

    int exp_x;
    int exp_y;
    bit exp_frame;

    task automatic shoot(input bit fast, input logic bv, input int bxv,
                         input int byv, input logic eh, input logic [4:0] ea,
                         input logic [10:0] es, input int tag);
        @(negedge clk);
        if (fast) begin
            b_valid_f = bv;
            bx_f      = 10'(bxv);
            by_f      = 9'(byv);
        end else begin
            b_valid   = bv;
            bx        = 10'(bxv);
            by        = 9'(byv);
        end
        exp_q.push_back('{cyc + 1, fast, eh, ea, es, tag});
    endtask

    task automatic bullets_off();
        @(negedge clk);
        b_valid   = 1'b0;
        b_valid_f = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic tick_once();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Returns the number of ticks up to and including the one that raised
    // move, or -1 when the budget runs out.
    task automatic ticks_to_move(input bit fast, input int limit,
                                 input string name, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick_once();
            if ((fast ? move_f : move) === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n < 0)
            bound_expired(name);
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_x"},     x,     exp_x);
        check({tag, "_y"},     y,     exp_y);
        check({tag, "_frame"}, frame, exp_frame);
        check({tag, "_left"},  left,  (exp_x <= 4) ? 1 : 0);
        check({tag, "_right"}, right, (exp_x >= 228) ? 1 : 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_x"},        x,        2);
        check({tag, "_y"},        y,        0);
        check({tag, "_alive"},    alive,    5'b11111);
        check({tag, "_score"},    score,    0);
        check({tag, "_b_hit"},    b_hit,    0);
        check({tag, "_move"},     move,     0);
        check({tag, "_frame"},    frame,    0);
        check({tag, "_gg"},       gg,       0);
        check({tag, "_all_dead"}, all_dead, 0);
        check({tag, "_left"},     left,     1);
        check({tag, "_right"},    right,    0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded 1000000 ns");
        $fatal(1, "watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    initial begin
        int n;
        int moves;

        // Offsets are relative to the model position x=226, y=8.
        hit_tab[0] = '{1'b1, 5, 16, 1'b1, 5'b11101, 11'd20};
        for (int i = 1; i <= 9; i++)
            hit_tab[i] = '{1'b1, 5, 16, 1'b0, 5'b11101, 11'd20};
        hit_tab[10] = '{1'b1, -1,  3, 1'b0, 5'b11101, 11'd20};
        hit_tab[11] = '{1'b1, 12,  3, 1'b0, 5'b11101, 11'd20};
        hit_tab[12] = '{1'b1,  0, 23, 1'b0, 5'b11101, 11'd20};
        hit_tab[13] = '{1'b0,  0, 26, 1'b0, 5'b11101, 11'd20};
        hit_tab[14] = '{1'b1,  0, 25, 1'b0, 5'b11101, 11'd20};
        hit_tab[15] = '{1'b1, 11,  7, 1'b1, 5'b11100, 11'd60};
        hit_tab[16] = '{1'b1,  5,  3, 1'b0, 5'b11100, 11'd60};
        hit_tab[17] = '{1'b1,  0, 26, 1'b1, 5'b11000, 11'd80};

        reset     = 1'b1;
        tick      = 1'b0;
        left_in   = 1'b0;
        right_in  = 1'b0;
        b_valid   = 1'b0;
        bx        = '0;
        by        = '0;
        b_valid_f = 1'b0;
        bx_f      = '0;
        by_f      = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset("rst0");
        exp_x     = 2;
        exp_y     = 0;
        exp_frame = 1'b0;

        // First step lands on tick 65; move lasts one tick period.
        ticks_to_move(1'b0, 200, "t1_first_step", n);
        check("t1_first_step_tick", n, 65);
        exp_x += 2;
        exp_frame ^= 1'b1;
        check_pos("t1_step");
        tick_once();
        check("t1_move_clears", move, 0);

        // March right until the column reaches the right edge.
        while (exp_x < 228) begin
            ticks_to_move(1'b0, 100, "t2_march", n);
            if (n < 0) break;
            exp_x += 2;
            exp_frame ^= 1'b1;
        end
        check_pos("t2_edge");

        right_in = 1'b1;
        ticks_to_move(1'b0, 100, "t2_drop", n);
        check("t2_drop_interval", n, 64);
        exp_y += 8;
        exp_frame ^= 1'b1;
        check_pos("t2_drop");

        right_in = 1'b0;
        ticks_to_move(1'b0, 100, "t2_step_left", n);
        exp_x -= 2;
        exp_frame ^= 1'b1;
        check_pos("t2_step_left");

        // Bullet vectors: box edges, held bullet, dead row, b_valid low.
        for (int i = 0; i < 18; i++)
            shoot(1'b0, hit_tab[i].bv, exp_x + hit_tab[i].dx,
                  exp_y + hit_tab[i].dy, hit_tab[i].eh, hit_tab[i].ea,
                  hit_tab[i].es, i);
        bullets_off();
        check("t3_all_dead_low", all_dead, 0);

        // Three dead: the next reload is 63-24=39, step interval 40.
        ticks_to_move(1'b0, 100, "t5_old_interval", n);
        check("t5_old_interval", n, 64);
        exp_x -= 2;
        exp_frame ^= 1'b1;
        ticks_to_move(1'b0, 100, "t5_new_interval", n);
        check("t5_new_interval", n, 40);
        exp_x -= 2;
        exp_frame ^= 1'b1;
        check_pos("t5_pos");

        // Both edge inputs high: every reversal is a drop.
        left_in  = 1'b1;
        right_in = 1'b1;
        for (int d = 0; d < 17; d++) begin
            ticks_to_move(1'b0, 100, "t6_drop", n);
            if (n < 0) break;
            exp_y += 8;
            exp_frame ^= 1'b1;
            check($sformatf("t6_drop%0d_y", d), y, exp_y);
            @(negedge clk);
            check($sformatf("t6_drop%0d_gg", d), gg,
                  (exp_y + 4 * 13 + 8 > 200) ? 1 : 0);
        end

        // Kill row 4 (gg must stay), hold, then row 3 to empty the column.
        shoot(1'b0, 1'b1, exp_x + 3, exp_y + 55, 1'b1, 5'b01000, 11'd90, 100);
        shoot(1'b0, 1'b1, exp_x + 3, exp_y + 55, 1'b0, 5'b01000, 11'd90, 101);
        shoot(1'b0, 1'b1, exp_x + 3, exp_y + 41, 1'b1, 5'b00000, 11'd100, 102);
        bullets_off();
        check("t6_gg_sticky",   gg,       1);
        check("t4_all_dead",    all_dead, 1);
        check("t4_left_dead",   left,     0);
        check("t4_right_dead",  right,    0);

        // Empty column is frozen: no moves, no position or frame change.
        moves = 0;
        repeat (100) begin
            tick_once();
            if (move !== 1'b0) moves++;
        end
        check("t4_frozen_moves", moves, 0);
        check("t4_frozen_x",     x,     exp_x);
        check("t4_frozen_y",     y,     exp_y);
        check("t4_frozen_frame", frame, exp_frame);

        // Reset restores everything and wins over a simultaneous bullet.
        left_in  = 1'b0;
        right_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset("rst1");
        b_valid = 1'b1;
        bx      = 10'd3;
        by      = 9'd1;
        @(negedge clk);
        check("rst_hit_b_hit", b_hit, 0);
        check("rst_hit_alive", alive, 5'b11111);
        check("rst_hit_score", score, 0);
        b_valid = 1'b0;
        reset   = 1'b0;

        // Fast instance: four kills drive 63-80 below the floor of 2.
        for (int r = 0; r < 4; r++)
            shoot(1'b1, 1'b1, 3, r * 13 + 1, 1'b1,
                  (r == 0) ? 5'b11110 : (r == 1) ? 5'b11100 :
                  (r == 2) ? 5'b11000 : 5'b10000,
                  (r == 0) ? 11'd40 : (r == 1) ? 11'd60 :
                  (r == 2) ? 11'd80 : 11'd90, 200 + r);
        bullets_off();
        ticks_to_move(1'b1, 200, "fast_first_step", n);
        check("fast_first_step_tick", n, 65);
        check("fast_first_step_x", x_f, 4);
        ticks_to_move(1'b1, 20, "fast_clamped", n);
        check("fast_clamped_interval", n, 3);

        repeat (2) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
